// File: rtl/modo1_detector_nota_if.sv
// Key and verdict bundle between the piano key front end and the mode-1 control unit.
interface modo1_detector_nota_if;
    logic [11:0] botoes;
    logic        tick_tempo;
    logic [3:0]  nota_esperada;
    logic [3:0]  tempo_esperado;
    logic        nota_feita;
    logic [3:0]  nota;
    logic        nota_correta;
    logic        tempo_correto;
    logic [4:0]  db_duracao;
    logic [1:0]  db_estado;

    modport master (
        output botoes, tick_tempo, nota_esperada, tempo_esperado,
        input  nota_feita, nota, nota_correta, tempo_correto, db_duracao, db_estado
    );

    modport slave (
        input  botoes, tick_tempo, nota_esperada, tempo_esperado,
        output nota_feita, nota, nota_correta, tempo_correto, db_duracao, db_estado
    );
endinterface

// File: rtl/modo1_detector_nota.sv
// Mode-1 key front end: synchronise, debounce and encode the 12 piano keys, then judge note and hold time.
// Optional duration measurement and tempo check are built when MODO1_DETECTOR_TEMPO_EN is defined.
module modo1_detector_nota #(
    parameter int DEBOUNCE   = 250000,
    parameter int TOLERANCIA = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    modo1_detector_nota_if.slave  bus
);
    localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        OCIOSO       = 2'd0,
        FILTRA_PRESS = 2'd1,
        PRESSIONADO  = 2'd2,
        FILTRA_SOLTA = 2'd3
    } estado_t;

    estado_t          estado_q, estado_d;
    logic [11:0]      sync1_q, sync1_d;
    logic [11:0]      botoes_s_q, botoes_s_d;
    logic [11:0]      captura_q, captura_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       nota_q, nota_d;
    logic             nota_feita_q, nota_feita_d;
    logic             nota_correta_q, nota_correta_d;
    logic             tempo_correto_q, tempo_correto_d;
    logic             soltura;

    // Lowest set bit wins when several keys form a chord.
    function automatic logic [3:0] menor_bit(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'hF;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        sync1_d    = bus.botoes;
        botoes_s_d = sync1_q;
        estado_d   = estado_q;
        captura_d  = captura_q;
        cnt_d      = cnt_q;
        nota_d     = nota_q;
        case (estado_q)
            OCIOSO: begin
                if (botoes_s_q != '0) begin
                    captura_d = botoes_s_q;
                    cnt_d     = '0;
                    estado_d  = FILTRA_PRESS;
                end
            end
            FILTRA_PRESS: begin
                if (botoes_s_q != captura_q) begin
                    estado_d = OCIOSO;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = PRESSIONADO;
                    nota_d   = menor_bit(captura_q);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSIONADO: begin
                if (botoes_s_q != captura_q) begin
                    cnt_d    = '0;
                    estado_d = FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (botoes_s_q == captura_q) begin
                    estado_d = PRESSIONADO;
                end else if (cnt_q == CNT_MAX) begin
                    estado_d = OCIOSO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: estado_d = OCIOSO;
        endcase
        nota_feita_d   = (estado_d == PRESSIONADO) || (estado_d == FILTRA_SOLTA);
        soltura        = (estado_q == FILTRA_SOLTA) && (estado_d == OCIOSO);
        nota_correta_d = soltura ? (nota_q == bus.nota_esperada) : nota_correta_q;
    end

`ifdef MODO1_DETECTOR_TEMPO_EN
    localparam logic [5:0] TOL6 = 6'(TOLERANCIA);

    logic [4:0] duracao_q, duracao_d;

    function automatic logic tempo_ok(input logic [4:0] dur, input logic [3:0] esperado);
        logic [5:0] a, b, d;
        a = {1'b0, dur};
        b = {2'b00, esperado};
        d = (a >= b) ? (a - b) : (b - a);
        return d <= TOL6;
    endfunction

    // A tick on the release edge is deliberately not counted.
    always_comb begin
        duracao_d = duracao_q;
        if ((estado_q == FILTRA_PRESS) && (estado_d == PRESSIONADO)) begin
            duracao_d = '0;
        end else if (bus.tick_tempo && nota_feita_q && !soltura && (duracao_q != 5'd31)) begin
            duracao_d = duracao_q + 5'd1;
        end
        tempo_correto_d = soltura ? tempo_ok(duracao_q, bus.tempo_esperado) : tempo_correto_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) duracao_q <= '0;
        else       duracao_q <= duracao_d;
    end

    assign bus.db_duracao = duracao_q;
`else
    logic unused_tempo;
    assign unused_tempo    = ^{bus.tick_tempo, bus.tempo_esperado};
    assign tempo_correto_d = soltura ? 1'b1 : tempo_correto_q;
    assign bus.db_duracao  = 5'd0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q        <= OCIOSO;
            sync1_q         <= '0;
            botoes_s_q      <= '0;
            captura_q       <= '0;
            cnt_q           <= '0;
            nota_q          <= 4'hF;
            nota_feita_q    <= 1'b0;
            nota_correta_q  <= 1'b0;
            tempo_correto_q <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            sync1_q         <= sync1_d;
            botoes_s_q      <= botoes_s_d;
            captura_q       <= captura_d;
            cnt_q           <= cnt_d;
            nota_q          <= nota_d;
            nota_feita_q    <= nota_feita_d;
            nota_correta_q  <= nota_correta_d;
            tempo_correto_q <= tempo_correto_d;
        end
    end

    assign bus.nota_feita    = nota_feita_q;
    assign bus.nota          = nota_q;
    assign bus.nota_correta  = nota_correta_q;
    assign bus.tempo_correto = tempo_correto_q;
    assign bus.db_estado     = estado_q;
endmodule

// File: tb/tb_modo1_detector_nota.sv
// Bench for modo1_detector_nota: directed scenarios plus randomized key activity against a run-length model.
module tb_modo1_detector_nota;
    localparam int DEB = 4;
    localparam int TOL = 1;
`ifdef MODO1_DETECTOR_TEMPO_EN
    localparam bit TEMPO_EN = 1'b1;
`else
    localparam bit TEMPO_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    modo1_detector_nota_if bus_if();

    modo1_detector_nota #(.DEBOUNCE(DEB), .TOLERANCIA(TOL)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: two-stage sampled keys, run lengths, verdicts.
    logic [11:0] m_sync1, m_s, m_key;
    int          m_run, m_rel, m_dur;
    bit          m_held, m_nc, m_tc;
    logic [3:0]  m_nota;

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] lowest(input logic [11:0] v);
        int k;
        k = 0;
        while (k < 12 && v[k] == 1'b0) k++;
        return 4'(k);
    endfunction

    task automatic model_reset();
        m_sync1 = '0; m_s = '0; m_key = '0;
        m_run = 0; m_rel = 0; m_dur = 0;
        m_held = 0; m_nc = 0; m_tc = 0;
        m_nota = 4'hF;
    endtask

    // Advances the model by one rising edge given the inputs that edge sampled.
    task automatic model_step(input logic [11:0] b, input logic tk,
                              input logic [3:0] ne, input logic [3:0] te);
        bit rel_now;
        int diff;
        rel_now = 0;
        if (!m_held) begin
            if (m_run == 0) begin
                if (m_s != 0) begin
                    m_key = m_s;
                    m_run = 1;
                end
            end else if (m_s != m_key) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_held = 1; m_nota = lowest(m_key); m_dur = 0; m_rel = 0;
                end
            end
        end else begin
            if (m_s == m_key) m_rel = 0;
            else begin
                m_rel++;
                rel_now = (m_rel == DEB + 1);
            end
            if (rel_now) begin
                m_held = 0; m_run = 0;
                m_nc = (m_nota == ne);
                diff = m_dur - int'(te);
                if (diff < 0) diff = -diff;
                m_tc = TEMPO_EN ? (diff <= TOL) : 1'b1;
            end else if (TEMPO_EN && tk && m_dur < 31) begin
                m_dur++;
            end
        end
        m_s = m_sync1;
        m_sync1 = b;
    endtask

    task automatic pulso_tick();
        bus_if.tick_tempo = 1'b1;
        ciclo();
        bus_if.tick_tempo = 1'b0;
        ciclo();
    endtask

    // Drives a press/hold/release; ok drops if either transition fails to appear in time.
    task automatic toca(input logic [11:0] key, input int ticks, output bit ok);
        ok = 1;
        bus_if.botoes = key;
        for (int i = 0; i < 20 && bus_if.nota_feita !== 1'b1; i++) ciclo();
        if (bus_if.nota_feita !== 1'b1) ok = 0;
        for (int i = 0; i < ticks; i++) pulso_tick();
        bus_if.botoes = '0;
        for (int i = 0; i < 20 && bus_if.nota_feita !== 1'b0; i++) ciclo();
        if (bus_if.nota_feita !== 1'b0) ok = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.botoes = '0; bus_if.tick_tempo = 0; bus_if.nota_esperada = 0; bus_if.tempo_esperado = 0;
        ciclo(); ciclo();
        n_checks++; if (bus_if.nota !== 4'hF) begin n_fail++; $display("FAIL reset_nota: got %h want F", bus_if.nota); end
        n_checks++; if (bus_if.nota_feita !== 1'b0) begin n_fail++; $display("FAIL reset_feita: got %b want 0", bus_if.nota_feita); end
        n_checks++; if (bus_if.nota_correta !== 1'b0 || bus_if.tempo_correto !== 1'b0) begin
            n_fail++; $display("FAIL reset_verdicts: got %b%b want 00", bus_if.nota_correta, bus_if.tempo_correto); end
        n_checks++; if (bus_if.db_duracao !== 5'd0) begin n_fail++; $display("FAIL reset_duracao: got %0d want 0", bus_if.db_duracao); end
        n_checks++; if (bus_if.db_estado !== 2'd0) begin n_fail++; $display("FAIL reset_estado: got %0d want 0", bus_if.db_estado); end
        reset = 1'b0;
        ciclo();
        bus_if.botoes = 12'h020;
        repeat (7) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b1 || bus_if.nota !== 4'd5) begin
            n_fail++; $display("FAIL reset_prepress: got feita=%b nota=%0d want 1/5", bus_if.nota_feita, bus_if.nota); end
        ciclo(); ciclo();
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus_if.nota !== 4'hF || bus_if.nota_feita !== 1'b0 || bus_if.db_estado !== 2'd0) begin
            n_fail++; $display("FAIL reset_async: got nota=%h feita=%b estado=%0d want F/0/0",
                               bus_if.nota, bus_if.nota_feita, bus_if.db_estado); end
        @(negedge clock);
        reset = 1'b0;
        repeat (6) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b0) begin n_fail++; $display("FAIL reset_repress_early: got %b want 0", bus_if.nota_feita); end
        ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b1) begin n_fail++; $display("FAIL reset_repress: got %b want 1", bus_if.nota_feita); end
        bus_if.botoes = '0;
        for (int i = 0; i < 20 && bus_if.nota_feita !== 1'b0; i++) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b0) begin n_fail++; $display("FAIL reset_release_timeout: got %b want 0", bus_if.nota_feita); end
        ciclo(); ciclo();
    endtask

    task automatic test_clean_press();
        bus_if.nota_esperada = 4'd4; bus_if.tempo_esperado = 4'd3;
        bus_if.botoes = 12'h010;
        repeat (6) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b0) begin n_fail++; $display("FAIL clean_press_early: got %b want 0", bus_if.nota_feita); end
        ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b1 || bus_if.nota !== 4'd4) begin
            n_fail++; $display("FAIL clean_press: got feita=%b nota=%0d want 1/4", bus_if.nota_feita, bus_if.nota); end
        repeat (3) pulso_tick();
        bus_if.botoes = '0;
        repeat (6) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b1) begin n_fail++; $display("FAIL clean_release_early: got %b want 1", bus_if.nota_feita); end
        ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b0) begin n_fail++; $display("FAIL clean_release: got %b want 0", bus_if.nota_feita); end
        n_checks++; if (bus_if.nota_correta !== 1'b1 || bus_if.tempo_correto !== 1'b1) begin
            n_fail++; $display("FAIL clean_verdicts: got %b%b want 11", bus_if.nota_correta, bus_if.tempo_correto); end
        n_checks++; if (bus_if.db_duracao !== (TEMPO_EN ? 5'd3 : 5'd0)) begin
            n_fail++; $display("FAIL clean_duracao: got %0d want %0d", bus_if.db_duracao, TEMPO_EN ? 3 : 0); end
        ciclo(); ciclo();
    endtask

    task automatic test_wrong_note();
        bit ok;
        bus_if.nota_esperada = 4'd2; bus_if.tempo_esperado = 4'd3;
        toca(12'h001, 5, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wrong_handshake: got ok=%b want 1", ok); end
        n_checks++; if (bus_if.nota !== 4'd0) begin n_fail++; $display("FAIL wrong_nota: got %0d want 0", bus_if.nota); end
        n_checks++; if (bus_if.nota_correta !== 1'b0) begin n_fail++; $display("FAIL wrong_nota_correta: got %b want 0", bus_if.nota_correta); end
        n_checks++; if (bus_if.tempo_correto !== !TEMPO_EN) begin
            n_fail++; $display("FAIL wrong_tempo_correto: got %b want %b", bus_if.tempo_correto, !TEMPO_EN); end
        n_checks++; if (bus_if.db_duracao !== (TEMPO_EN ? 5'd5 : 5'd0)) begin
            n_fail++; $display("FAIL wrong_duracao: got %0d want %0d", bus_if.db_duracao, TEMPO_EN ? 5 : 0); end
        ciclo(); ciclo();
    endtask

    task automatic test_bounce();
        bit seen, fell;
        bus_if.botoes = 12'h008;
        ciclo(); ciclo();
        bus_if.botoes = '0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin ciclo(); seen |= bus_if.nota_feita; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bounce_press: got feita seen=%b want 0", seen); end
        n_checks++; if (bus_if.nota !== 4'd0) begin n_fail++; $display("FAIL bounce_nota_held: got %0d want 0", bus_if.nota); end
        bus_if.nota_esperada = 4'd1; bus_if.tempo_esperado = 4'd2;
        bus_if.botoes = 12'h002;
        for (int i = 0; i < 20 && bus_if.nota_feita !== 1'b1; i++) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b1) begin n_fail++; $display("FAIL glitch_press_timeout: got %b want 1", bus_if.nota_feita); end
        pulso_tick();
        bus_if.botoes = '0; bus_if.tick_tempo = 1'b1;
        ciclo();
        bus_if.tick_tempo = 1'b0;
        ciclo();
        bus_if.botoes = 12'h002;
        fell = 0;
        for (int i = 0; i < 10; i++) begin ciclo(); fell |= !bus_if.nota_feita; end
        n_checks++; if (fell !== 1'b0) begin n_fail++; $display("FAIL glitch_hold: got fell=%b want 0", fell); end
        bus_if.botoes = '0;
        for (int i = 0; i < 20 && bus_if.nota_feita !== 1'b0; i++) ciclo();
        n_checks++; if (bus_if.nota_feita !== 1'b0) begin n_fail++; $display("FAIL glitch_release_timeout: got %b want 0", bus_if.nota_feita); end
        n_checks++; if (bus_if.db_duracao !== (TEMPO_EN ? 5'd2 : 5'd0)) begin
            n_fail++; $display("FAIL glitch_duracao: got %0d want %0d", bus_if.db_duracao, TEMPO_EN ? 2 : 0); end
        n_checks++; if (bus_if.nota_correta !== 1'b1 || bus_if.tempo_correto !== 1'b1) begin
            n_fail++; $display("FAIL glitch_verdicts: got %b%b want 11", bus_if.nota_correta, bus_if.tempo_correto); end
        ciclo(); ciclo();
    endtask

    task automatic test_chord_saturation();
        bit ok;
        bus_if.nota_esperada = 4'd6; bus_if.tempo_esperado = 4'd15;
        toca(12'h0C0, 40, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL chord_handshake: got ok=%b want 1", ok); end
        n_checks++; if (bus_if.nota !== 4'd6) begin n_fail++; $display("FAIL chord_nota: got %0d want 6", bus_if.nota); end
        n_checks++; if (bus_if.db_duracao !== (TEMPO_EN ? 5'd31 : 5'd0)) begin
            n_fail++; $display("FAIL sat_duracao: got %0d want %0d", bus_if.db_duracao, TEMPO_EN ? 31 : 0); end
        n_checks++; if (bus_if.tempo_correto !== !TEMPO_EN || bus_if.nota_correta !== 1'b1) begin
            n_fail++; $display("FAIL sat_verdicts: got nc=%b tc=%b want 1/%b", bus_if.nota_correta, bus_if.tempo_correto, !TEMPO_EN); end
        ciclo(); ciclo();
    endtask

    task automatic test_random();
        logic [11:0] b;
        int len, sel;
        bus_if.botoes = '0; bus_if.tick_tempo = 0;
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        model_reset();
        for (int ep = 0; ep < 70; ep++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      b = 12'(1 << $urandom_range(0, 11));
            else if (sel == 1) b = 12'($urandom_range(1, 4095));
            else               b = '0;
            len = (sel >= 2) ? $urandom_range(1, 12) : $urandom_range(1, 30);
            for (int c = 0; c < len; c++) begin
                bus_if.botoes = b;
                bus_if.tick_tempo = ($urandom_range(0, 2) == 0);
                bus_if.nota_esperada = $urandom_range(0, 1) ? m_nota : 4'($urandom_range(0, 11));
                bus_if.tempo_esperado = ($urandom_range(0, 1) && m_dur < 16) ? 4'(m_dur) : 4'($urandom_range(0, 15));
                ciclo();
                model_step(b, bus_if.tick_tempo, bus_if.nota_esperada, bus_if.tempo_esperado);
                n_checks++; if (bus_if.nota_feita !== m_held) begin
                    n_fail++; $display("FAIL rnd_feita ep%0d: got %b want %b", ep, bus_if.nota_feita, m_held); end
                n_checks++; if (bus_if.nota !== m_nota) begin
                    n_fail++; $display("FAIL rnd_nota ep%0d: got %0d want %0d", ep, bus_if.nota, m_nota); end
                n_checks++; if (bus_if.nota_correta !== m_nc) begin
                    n_fail++; $display("FAIL rnd_nota_correta ep%0d: got %b want %b", ep, bus_if.nota_correta, m_nc); end
                n_checks++; if (bus_if.tempo_correto !== m_tc) begin
                    n_fail++; $display("FAIL rnd_tempo_correto ep%0d: got %b want %b", ep, bus_if.tempo_correto, m_tc); end
                n_checks++; if (bus_if.db_duracao !== 5'(m_dur)) begin
                    n_fail++; $display("FAIL rnd_duracao ep%0d: got %0d want %0d", ep, bus_if.db_duracao, m_dur); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_wrong_note();
        test_bounce();
        test_chord_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
